// File: rtl/occ_pkg.sv
// Shared definitions for the Occ table server: default geometry and FSM encoding.
package occ_pkg;

    localparam int unsigned OCC_ADDR_W = 8;
    localparam int unsigned OCC_DATA_W = 32;
    localparam int unsigned OCC_DEPTH  = 256;
    localparam int unsigned OCC_RD_LAT = 2;

    typedef enum logic {
        OCC_CLEAR = 1'b0,
        OCC_READY = 1'b1
    } occ_state_e;

endpackage

// File: rtl/occ_ram_1r1w.sv
// Synchronous 1-read/1-write RAM, write-first, registered read data that holds when idle.
module occ_ram_1r1w #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              rd_in_range;

    assign rd_in_range = {1'b0, raddr} < DEPTH_X;

    // Addresses beyond the table read as zero; a same-cycle write bypasses the array.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (!rd_in_range) begin
                rdata_d = '0;
            end else if (we && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/occ_mem_server.sv
// Loadable Occ table: zero-fills after reset, then serves pipelined reads at RD_LAT latency.
module occ_mem_server
    import occ_pkg::*;
#(
    parameter int unsigned ADDR_W = OCC_ADDR_W,
    parameter int unsigned DATA_W = OCC_DATA_W,
    parameter int unsigned DEPTH  = OCC_DEPTH,
    parameter int unsigned RD_LAT = OCC_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ran_we_Occ,
    input  logic [ADDR_W-1:0] ran_w_addr_Occ,
    input  logic [DATA_W-1:0] ran_w_data_Occ,
    output logic              ready
);

    localparam int unsigned     CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    occ_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                ready_q, ready_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [DATA_W-1:0]   ram_rdata;
    logic                w_in_range;

    assign w_in_range = {1'b0, ran_w_addr_Occ} < DEPTH_X;

    // Next state: clear sweep owns the write port in CLEAR, host owns it in READY.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        ram_raddr   = addr;

        case (state_q)
            OCC_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = ADDR_W'(cnt_q);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = OCC_READY;
                end
                if (ce) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = addr;
                end
            end
            OCC_READY: begin
                ram_we     = ran_we_Occ && w_in_range;
                ram_waddr  = ran_w_addr_Occ;
                ram_wdata  = ran_w_data_Occ;
                ram_re     = ce || pend_vld_q;
                ram_raddr  = ce ? addr : pend_addr_q;
                pend_vld_d = 1'b0;
            end
            default: begin
                state_d = OCC_CLEAR;
            end
        endcase

        ready_d  = (state_d == OCC_READY);
        vld_d[0] = ram_re;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_CLEAR;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            ready_q     <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            ready_q     <= ready_d;
            vld_q       <= vld_d;
        end
    end

    occ_ram_1r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Data alignment: each stage advances only when its request does, so the output holds between pulses.
    if (RD_LAT == 1) begin : g_lat1
        assign data = ram_rdata;
    end else begin : g_latn
        logic [DATA_W-1:0] dat_q [RD_LAT-1];
        logic [DATA_W-1:0] dat_d [RD_LAT-1];

        always_comb begin
            dat_d[0] = vld_q[0] ? ram_rdata : dat_q[0];
            for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
                dat_d[i] = vld_q[i] ? dat_q[i-1] : dat_q[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end

        assign data = dat_q[RD_LAT-2];
    end

    assign valid = vld_q[RD_LAT-1];
    assign ready = ready_q;

endmodule

// File: tb/tb_occ_mem_server.sv
// Directed bench for occ_mem_server: default build plus a DEPTH=200 build for range masking.
module tb_occ_mem_server;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ce, we, valid, ready;
    logic [7:0]  addr, waddr;
    logic [31:0] wdata, data;

    logic        rst2_n, ce2, we2, valid2, ready2;
    logic [7:0]  addr2, waddr2;
    logic [31:0] wdata2, data2;

    int n_checks = 0;
    int n_errors = 0;

    occ_mem_server u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce             (ce),
        .addr           (addr),
        .data           (data),
        .valid          (valid),
        .ran_we_Occ     (we),
        .ran_w_addr_Occ (waddr),
        .ran_w_data_Occ (wdata),
        .ready          (ready)
    );

    occ_mem_server #(.DEPTH(200)) u_dut200 (
        .clk            (clk),
        .rst_n          (rst2_n),
        .ce             (ce2),
        .addr           (addr2),
        .data           (data2),
        .valid          (valid2),
        .ran_we_Occ     (we2),
        .ran_w_addr_Occ (waddr2),
        .ran_w_data_Occ (wdata2),
        .ready          (ready2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back reads of 0..255; response for addr s-1 is seen after the edge of iteration s.
    task automatic read_sweep(input string tag, input bit pat);
        for (int s = 0; s < 260; s++) begin
            ce   = (s < 256);
            addr = 8'(s);
            step();
            if (s >= 1 && s <= 256) begin
                check({tag, "_valid"}, 32'(valid), 32'd1);
                check({tag, "_data"}, data, pat ? (32'hDEAD_0000 + 32'(s - 1)) : 32'h0);
            end else begin
                check({tag, "_idle"}, 32'(valid), 32'd0);
            end
        end
        ce = 1'b0;
    endtask

    task automatic wr_rd2(input string tag, input logic [7:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
        we2 = 1'b1; waddr2 = a; wdata2 = wd;
        step();
        we2 = 1'b0; ce2 = 1'b1; addr2 = a;
        step();
        ce2 = 1'b0;
        step();
        check({tag, "_valid"}, 32'(valid2), 32'd1);
        check({tag, "_data"}, data2, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int ready_at;

        rst_n = 1'b0; ce = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
        rst2_n = 1'b0; ce2 = 1'b0; addr2 = '0; we2 = 1'b0; waddr2 = '0; wdata2 = '0;
        repeat (3) step();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);

        // CLEAR phase: two pending reads (latest wins) and a dropped host write.
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 262; n++) begin
            ce    = (n == 10) || (n == 11);
            addr  = (n == 10) ? 8'h05 : 8'h07;
            we    = (n == 11);
            waddr = 8'h07;
            wdata = 32'hFFFF_FFFF;
            step();
            if (n == 255) check("clear_ready_lo", 32'(ready), 32'd0);
            if (n == 256) check("clear_ready_hi", 32'(ready), 32'd1);
            if (valid) begin
                pulses++;
                check("pend_cycle", 32'(n), 32'd258);
                check("pend_data", data, 32'h0);
            end
        end
        ce = 1'b0; we = 1'b0;
        check("pend_pulses", 32'(pulses), 32'd1);

        read_sweep("zero", 1'b0);

        for (int i = 0; i < 256; i++) begin
            we = 1'b1; waddr = 8'(i); wdata = 32'hDEAD_0000 + 32'(i);
            step();
        end
        we = 1'b0;
        read_sweep("pat", 1'b1);

        // Reset with two reads in flight.
        ce = 1'b1; addr = 8'h03;
        step();
        addr = 8'h04;
        step();
        ce = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        pulses   = 0;
        ready_at = -1;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (valid) pulses++;
            if (ready && ready_at < 0) ready_at = n;
        end
        check("midrst_pulses", 32'(pulses), 32'd0);
        check("midrst_ready_at", 32'(ready_at), 32'd256);
        read_sweep("rezero", 1'b0);

        // Write-first ordering at addr 0x40, then write-then-read at 0x41.
        ce = 1'b1; addr = 8'h40;
        step();
        ce = 1'b0;
        step();
        check("wf_prior_valid", 32'(valid), 32'd1);
        check("wf_prior_data", data, 32'h0);
        ce = 1'b1; addr = 8'h40; we = 1'b1; waddr = 8'h40; wdata = 32'h1234_5678;
        step();
        ce = 1'b0; we = 1'b0;
        step();
        check("wf_same_valid", 32'(valid), 32'd1);
        check("wf_same_data", data, 32'h1234_5678);
        we = 1'b1; waddr = 8'h41; wdata = 32'hA5A5_A5A5;
        step();
        we = 1'b0; ce = 1'b1; addr = 8'h41;
        step();
        ce = 1'b0;
        step();
        check("wf_next_valid", 32'(valid), 32'd1);
        check("wf_next_data", data, 32'hA5A5_A5A5);
        step();
        check("hold_valid", 32'(valid), 32'd0);
        check("hold_data", data, 32'hA5A5_A5A5);

        // DEPTH=200 build: clear length and out-of-range handling.
        rst2_n   = 1'b1;
        ready_at = -1;
        for (int n = 1; n <= 400 && ready_at < 0; n++) begin
            step();
            if (ready2) ready_at = n;
        end
        check("d200_ready_at", 32'(ready_at), 32'd200);
        wr_rd2("d200_f0", 8'hF0, 32'hCAFE_F00D, 32'h0);
        wr_rd2("d200_c7", 8'hC7, 32'h1111_2222, 32'h1111_2222);
        wr_rd2("d200_c8", 8'hC8, 32'h3333_4444, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
